chip8_mem: RTL and testbench

- 4 KiB CHIP-8 main memory: byte-wide RAM plus a boot sequencer.
- Sits directly upstream of the CPU core, supplying instruction and data bytes on its memory port.
- After reset it writes the built-in hex font, then accepts a ROM byte stream from the host/loader into 0x200 onward.
- Only after loading completes does it raise cpu_run to let the CPU execute.

---
 rtl/chip8_pkg.sv | 43 ++++
 rtl/chip8_ram.sv | 38 +++
 rtl/chip8_mem.sv | 209 ++++++++++++++++++++
 tb/tb_chip8_mem.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chip8_pkg
// Description : Shared constants and types for the CHIP-8 main memory block:
//               memory map, sequencer state encoding and the built-in hex font.
// Revision    : 1.0  initial release
// ============================================================================
package chip8_pkg;

  localparam logic [11:0] FONT_BASE  = 12'h050;  // first byte of the hex font
  localparam logic [11:0] PROG_BASE  = 12'h200;  // ROM load / CPU start address
  localparam int          MEM_DEPTH  = 4096;     // bytes, 12-bit address
  localparam int          FONT_BYTES = 80;       // 16 glyphs x 5 rows

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_FONT  = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  // Standard CHIP-8 glyphs 0..F, five rows each, MSB-aligned 4-pixel rows.
  localparam logic [7:0] FONT [0:79] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  // 0
    8'h20, 8'h60, 8'h20, 8'h20, 8'h70,  // 1
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  // 2
    8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,  // 3
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  // 4
    8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,  // 5
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  // 6
    8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,  // 7
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  // 8
    8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,  // 9
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  // A
    8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,  // B
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  // C
    8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,  // D
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  // E
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80   // F
  };

endpackage
`default_nettype wire

// File: rtl/chip8_ram.sv
`default_nettype none
// ============================================================================
// Module      : chip8_ram
// Description : Byte-wide RAM with one asynchronous read port and one
//               synchronous write port. Read-during-write to the same address
//               returns the old byte until the clock edge.
// Ports       : clk    - write clock
//               we     - write enable
//               waddr  - write address
//               wdata  - write data
//               raddr  - read address
//               rdata  - combinational read data
// Revision    : 1.0  initial release
// ============================================================================
module chip8_ram #(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/chip8_mem.sv
`default_nettype none
// ============================================================================
// Module      : chip8_mem
// Description : 4 KiB CHIP-8 main memory with boot sequencer. After reset it
//               writes the hex font, then accepts a ROM byte stream at 0x200
//               onward, then raises cpu_run and serves the CPU memory port.
//               Optional macro CHIP8_MEM_CLEAR_EN adds a CLEAR state that
//               zeroes all of RAM after reset and before every reload.
// Ports       : clk, reset          - clock, async active-high reset
//               cpu_addr/rd/we/wdata - CPU memory port (rd informational)
//               cpu_rdata            - async read data, 0 while not running
//               cpu_run              - memory ready, CPU may execute
//               ld_start             - pulse: (re)start ROM load
//               ld_valid/data/last   - loader byte stream
//               ld_ready             - loader byte accepted this cycle
//               ld_error             - sticky: ROM overflowed, bytes dropped
//               ld_count             - bytes written by current/last load
// Revision    : 1.0  initial release
// ============================================================================
module chip8_mem
  import chip8_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_run,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        ld_error,
  output logic [11:0] ld_count
);

`ifdef CHIP8_MEM_CLEAR_EN
  // Clearing wipes the font too, so CLEAR is always followed by FONT.
  localparam state_t C_RESET_STATE   = ST_CLEAR;
  localparam state_t C_RESTART_STATE = ST_CLEAR;
`else
  localparam state_t C_RESET_STATE   = ST_FONT;
  localparam state_t C_RESTART_STATE = ST_LOAD;
`endif

  state_t      r_state;
  state_t      w_state_next;
  logic [6:0]  r_font_idx;
  // Bit 12 set means the pointer has run past 0xFFF; further bytes are dropped.
  logic [12:0] r_ld_ptr;
  logic [11:0] r_ld_count;
  logic        r_ld_error;
`ifdef CHIP8_MEM_CLEAR_EN
  logic [11:0] r_clear_idx;
`endif

  logic        w_we;
  logic [11:0] w_waddr;
  logic [7:0]  w_wdata;
  logic [7:0]  w_rdata;
  logic        w_ld_restart;
  logic        w_ld_accept;
  logic        w_font_last;
  logic        w_unused;

  // Reads are continuous; the strobe carries no information for this block.
  assign w_unused    = cpu_rd;
  assign w_font_last = (r_font_idx == 7'(FONT_BYTES - 1));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= C_RESET_STATE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state, status outputs and write-port mux. The writer is selected by
  // state alone, so loader and CPU can never collide on the write port.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_we         = 1'b0;
    w_waddr      = cpu_addr;
    w_wdata      = cpu_wdata;
    w_ld_restart = 1'b0;
    w_ld_accept  = 1'b0;
    cpu_run      = 1'b0;
    ld_ready     = 1'b0;

    case (r_state)
`ifdef CHIP8_MEM_CLEAR_EN
      ST_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_clear_idx;
        w_wdata = 8'h00;
        if (r_clear_idx == 12'hFFF) begin
          w_state_next = ST_FONT;
        end
      end
`endif
      ST_FONT: begin
        w_we    = 1'b1;
        w_waddr = FONT_BASE + {5'd0, r_font_idx};
        w_wdata = FONT[r_font_idx];
        if (w_font_last) begin
          w_state_next = ST_LOAD;
        end
      end

      ST_LOAD: begin
        ld_ready = 1'b1;
        if (ld_start) begin
          // Restart wins: a byte presented in the same cycle is discarded.
          w_ld_restart = 1'b1;
        end else if (ld_valid) begin
          w_ld_accept = 1'b1;
          if (!r_ld_ptr[12]) begin
            w_we    = 1'b1;
            w_waddr = r_ld_ptr[11:0];
            w_wdata = ld_data;
          end
          if (ld_last) begin
            w_state_next = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        cpu_run = 1'b1;
        w_we    = cpu_we;
        if (ld_start) begin
          w_ld_restart = 1'b1;
          w_state_next = C_RESTART_STATE;
        end
      end

      default: begin
        w_state_next = C_RESET_STATE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequencer counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_font_idx <= 7'd0;
    end else if (r_state == ST_FONT) begin
      // Return to zero on exit so a later CLEAR->FONT pass starts cleanly.
      r_font_idx <= w_font_last ? 7'd0 : r_font_idx + 7'd1;
    end
  end

`ifdef CHIP8_MEM_CLEAR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clear_idx <= 12'd0;
    end else if (r_state == ST_CLEAR) begin
      r_clear_idx <= r_clear_idx + 12'd1;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ld_ptr   <= {1'b0, PROG_BASE};
      r_ld_count <= 12'd0;
      r_ld_error <= 1'b0;
    end else if (w_ld_restart) begin
      r_ld_ptr   <= {1'b0, PROG_BASE};
      r_ld_count <= 12'd0;
      r_ld_error <= 1'b0;
    end else if (w_ld_accept) begin
      if (!r_ld_ptr[12]) begin
        r_ld_ptr   <= r_ld_ptr + 13'd1;
        r_ld_count <= r_ld_count + 12'd1;
      end else begin
        r_ld_error <= 1'b1;
      end
    end
  end

  assign ld_count  = r_ld_count;
  assign ld_error  = r_ld_error;
  assign cpu_rdata = cpu_run ? w_rdata : 8'h00;

  chip8_ram #(
    .DEPTH  (MEM_DEPTH),
    .ADDR_W (12)
  ) u_ram (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (w_wdata),
    .raddr (cpu_addr),
    .rdata (w_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_chip8_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_chip8_mem
// Description : Self-checking bench for chip8_mem. Randomised loader streams
//               and CPU writes are checked against a byte-array model of the
//               memory plus pointer/count/error bookkeeping.
// Revision    : 1.0  initial release
// ============================================================================
module tb_chip8_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_we;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_run;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_error;
  logic [11:0] ld_count;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [7:0] ref_mem   [4096];
  bit         ref_known [4096];
  int         ref_ptr;
  int         ref_count;
  bit         ref_error;

  logic [7:0] font_tab [80] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  chip8_mem dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_rd    (cpu_rd),
    .cpu_we    (cpu_we),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_run   (cpu_run),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .ld_error  (ld_error),
    .ld_count  (ld_count)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- model
  task automatic model_restart();
    ref_ptr   = 'h200;
    ref_count = 0;
    ref_error = 1'b0;
  endtask

  task automatic model_font();
    for (int i = 0; i < 80; i++) begin
      ref_mem['h50 + i]   = font_tab[i];
      ref_known['h50 + i] = 1'b1;
    end
  endtask

  task automatic model_accept(input logic [7:0] d);
    if (ref_ptr < 4096) begin
      ref_mem[ref_ptr]   = d;
      ref_known[ref_ptr] = 1'b1;
      ref_ptr++;
      ref_count++;
    end else begin
      ref_error = 1'b1;
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic send_byte(input logic [7:0] d, input bit last, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        ld_valid = 1'b0;
        ld_data  = 8'($urandom);
      end
    end
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    @(posedge clk);
    model_accept(d);
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic read_mem(input logic [11:0] a, output logic [7:0] d);
    @(negedge clk);
    cpu_addr = a;
    #1;
    d = cpu_rdata;
  endtask

  task automatic do_restart();
    @(negedge clk);
    ld_start = 1'b1;
    @(posedge clk);
    model_restart();
    #1;
    ld_start = 1'b0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    reset     = 1'b1;
    cpu_addr  = 12'($urandom);
    cpu_rd    = 1'b1;
    cpu_we    = 1'b0;
    cpu_wdata = 8'h00;
    ld_start  = 1'b0;
    ld_valid  = 1'b0;
    ld_data   = 8'h00;
    ld_last   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cpu_run !== 1'b0)    begin errors++; $display("FAIL reset_cpu_run: got %b want 0", cpu_run); end
    checks++; if (ld_ready !== 1'b0)   begin errors++; $display("FAIL reset_ld_ready: got %b want 0", ld_ready); end
    checks++; if (ld_error !== 1'b0)   begin errors++; $display("FAIL reset_ld_error: got %b want 0", ld_error); end
    checks++; if (ld_count !== 12'h0)  begin errors++; $display("FAIL reset_ld_count: got %h want 000", ld_count); end
    checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", cpu_rdata); end
    model_restart();
  endtask

  task automatic test_font();
    logic [7:0] d, b;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk);
      #1;
      if (i == 79) begin
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL font_ready_early: got %b want 0 at cycle 79", ld_ready); end
      end
    end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL font_ready_80: got %b want 1", ld_ready); end
    checks++; if (cpu_run !== 1'b0)  begin errors++; $display("FAIL font_cpu_run: got %b want 0", cpu_run); end
    model_font();
    d = 8'($urandom);
    send_byte(d, 1'b1, 1'b0);
    checks++; if (cpu_run !== 1'b1) begin errors++; $display("FAIL font_run_after_last: got %b want 1", cpu_run); end
    for (int i = 0; i < 80; i++) begin
      read_mem(12'('h50 + i), b);
      checks++;
      if (b !== font_tab[i]) begin errors++; $display("FAIL font_byte[%0d]: got %h want %h", i, b, font_tab[i]); end
    end
    read_mem(12'h200, b);
    checks++; if (b !== d) begin errors++; $display("FAIL font_load1: got %h want %h", b, d); end
  endtask

  task automatic test_load();
    logic [7:0] pat [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    logic [7:0] b;
    do_restart();
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %b want 1", ld_ready); end
    checks++; if (cpu_run !== 1'b0)  begin errors++; $display("FAIL load_run_low: got %b want 0", cpu_run); end
    for (int i = 0; i < 4; i++) begin
      send_byte(pat[i], i == 3, 1'b1);
      if (i == 2) begin
        checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL load_run_early: got %b want 0", cpu_run); end
      end
    end
    checks++; if (cpu_run !== 1'b1)           begin errors++; $display("FAIL load_run: got %b want 1", cpu_run); end
    checks++; if (ld_count !== 12'(ref_count)) begin errors++; $display("FAIL load_count: got %h want %h", ld_count, 12'(ref_count)); end
    checks++; if (ld_error !== 1'b0)          begin errors++; $display("FAIL load_error: got %b want 0", ld_error); end
    for (int i = 0; i < 4; i++) begin
      read_mem(12'('h200 + i), b);
      checks++; if (b !== pat[i]) begin errors++; $display("FAIL load_byte[%0d]: got %h want %h", i, b, pat[i]); end
    end
  endtask

  task automatic test_cpu_write();
    logic [7:0] r1, b;
    int a;
    r1 = 8'($urandom);
    // first write to 0x300, then overwrite while checking read-during-write
    @(negedge clk); cpu_addr = 12'h300; cpu_wdata = r1; cpu_we = 1'b1;
    @(posedge clk); #1; cpu_we = 1'b0;
    ref_mem['h300] = r1; ref_known['h300] = 1'b1;
    @(negedge clk); cpu_addr = 12'h300; cpu_wdata = 8'hAB; cpu_we = 1'b1;
    #1;
    checks++; if (cpu_rdata !== r1) begin errors++; $display("FAIL cpu_rdw_old: got %h want %h", cpu_rdata, r1); end
    @(posedge clk); #1; cpu_we = 1'b0;
    ref_mem['h300] = 8'hAB;
    read_mem(12'h300, b);
    checks++; if (b !== 8'hAB) begin errors++; $display("FAIL cpu_write: got %h want AB", b); end
    // random writes below PROG_BASE, outside the font
    for (int i = 0; i < 6; i++) begin
      do a = $urandom_range(0, 'h1FF); while (a >= 'h50 && a < 'hA0);
      @(negedge clk); cpu_addr = 12'(a); cpu_wdata = 8'($urandom); cpu_we = 1'b1;
      ref_mem[a] = cpu_wdata; ref_known[a] = 1'b1;
      @(posedge clk); #1; cpu_we = 1'b0;
    end
    // CPU write attempt during LOAD must be ignored
    do_restart();
    @(negedge clk); cpu_addr = 12'h300; cpu_wdata = 8'hCD; cpu_we = 1'b1;
    @(posedge clk); #1; cpu_we = 1'b0;
    send_byte(8'($urandom), 1'b1, 1'b1);
    read_mem(12'h300, b);
    checks++; if (b !== 8'hAB)  begin errors++; $display("FAIL cpu_write_in_load: got %h want AB", b); end
    checks++; if (ld_count !== 12'd1) begin errors++; $display("FAIL cpu_write_count: got %h want 001", ld_count); end
  endtask

  task automatic test_overflow();
    logic [7:0] d, b, at_fff;
    do_restart();
    at_fff = 8'h00;
    for (int i = 0; i < 3586; i++) begin
      d = 8'($urandom);
      if (i == 3583) at_fff = d;
      send_byte(d, i == 3585, ($urandom_range(0, 7) == 0));
      if (i == 3583) begin
        checks++; if (ld_count !== 12'hE00) begin errors++; $display("FAIL ovf_count_full: got %h want E00", ld_count); end
        checks++; if (ld_error !== 1'b0)    begin errors++; $display("FAIL ovf_error_early: got %b want 0", ld_error); end
      end
    end
    checks++; if (ld_count !== 12'(ref_count)) begin errors++; $display("FAIL ovf_count: got %h want %h", ld_count, 12'(ref_count)); end
    checks++; if (ld_error !== ref_error)       begin errors++; $display("FAIL ovf_error: got %b want %b", ld_error, ref_error); end
    checks++; if (cpu_run !== 1'b1)            begin errors++; $display("FAIL ovf_run: got %b want 1", cpu_run); end
    read_mem(12'hFFF, b);
    checks++; if (b !== at_fff) begin errors++; $display("FAIL ovf_fff: got %h want %h", b, at_fff); end
    for (int a = 0; a < 'h200; a++) begin
      if (ref_known[a]) begin
        read_mem(12'(a), b);
        checks++; if (b !== ref_mem[a]) begin errors++; $display("FAIL ovf_low[%h]: got %h want %h", a, b, ref_mem[a]); end
      end
    end
  endtask

  task automatic test_restart();
    logic [7:0] d0, d1, b;
    do_restart();
    checks++; if (cpu_run !== 1'b0)    begin errors++; $display("FAIL rst_run: got %b want 0", cpu_run); end
    checks++; if (ld_ready !== 1'b1)   begin errors++; $display("FAIL rst_ready: got %b want 1", ld_ready); end
    checks++; if (ld_count !== 12'h0)  begin errors++; $display("FAIL rst_count: got %h want 000", ld_count); end
    checks++; if (ld_error !== 1'b0)   begin errors++; $display("FAIL rst_error: got %b want 0", ld_error); end
    // byte presented together with ld_start is discarded
    @(negedge clk); ld_start = 1'b1; ld_valid = 1'b1; ld_data = 8'($urandom);
    @(posedge clk); model_restart();
    #1; ld_start = 1'b0; ld_valid = 1'b0;
    checks++; if (ld_count !== 12'h0) begin errors++; $display("FAIL rst_discard: got %h want 000", ld_count); end
    d0 = 8'($urandom); d1 = 8'($urandom);
    send_byte(d0, 1'b0, 1'b1);
    send_byte(d1, 1'b1, 1'b1);
    checks++; if (ld_count !== 12'd2) begin errors++; $display("FAIL rst_count2: got %h want 002", ld_count); end
    read_mem(12'h200, b);
    checks++; if (b !== d0) begin errors++; $display("FAIL rst_200: got %h want %h", b, d0); end
    read_mem(12'h201, b);
    checks++; if (b !== d1) begin errors++; $display("FAIL rst_201: got %h want %h", b, d1); end
    for (int i = 0; i < 80; i++) begin
      read_mem(12'('h50 + i), b);
      checks++; if (b !== font_tab[i]) begin errors++; $display("FAIL rst_font[%0d]: got %h want %h", i, b, font_tab[i]); end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] b;
    logic [7:0] pat [4];
    do_restart();
    for (int i = 0; i < 4; i++) pat[i] = 8'($urandom);
    send_byte(pat[0], 1'b0, 1'b1);
    send_byte(pat[1], 1'b0, 1'b1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (ld_ready !== 1'b0)  begin errors++; $display("FAIL mid_ready: got %b want 0", ld_ready); end
    checks++; if (ld_count !== 12'h0) begin errors++; $display("FAIL mid_count: got %h want 000", ld_count); end
    checks++; if (cpu_run !== 1'b0)   begin errors++; $display("FAIL mid_run: got %b want 0", cpu_run); end
    checks++; if (ld_error !== 1'b0)  begin errors++; $display("FAIL mid_error: got %b want 0", ld_error); end
    model_restart();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk);
      #1;
      if (i == 79) begin
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL mid_font_early: got %b want 0", ld_ready); end
      end
    end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL mid_font_80: got %b want 1", ld_ready); end
    for (int i = 0; i < 4; i++) send_byte(pat[i], i == 3, 1'b1);
    checks++; if (ld_count !== 12'd4) begin errors++; $display("FAIL mid_count4: got %h want 004", ld_count); end
    for (int i = 0; i < 4; i++) begin
      read_mem(12'('h200 + i), b);
      checks++; if (b !== pat[i]) begin errors++; $display("FAIL mid_byte[%0d]: got %h want %h", i, b, pat[i]); end
    end
  endtask

  task automatic test_final_image();
    logic [7:0] b;
    for (int a = 0; a < 4096; a++) begin
      if (ref_known[a]) begin
        read_mem(12'(a), b);
        checks++; if (b !== ref_mem[a]) begin errors++; $display("FAIL image[%h]: got %h want %h", a, b, ref_mem[a]); end
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) ref_known[a] = 1'b0;
    test_reset();
    test_font();
    test_load();
    test_cpu_write();
    test_overflow();
    test_restart();
    test_reset_mid_load();
    test_final_image();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
